// File: rtl/bus_fifo_slave.sv
// -----------------------------------------------------------------------------
// bus_fifo_slave
//
// Memory-mapped FIFO responder on the slave side of the system bus. A master
// pushes 32-bit words by writing the DATA register and pops them, in order,
// by reading DATA. Control, status, threshold and interrupt-clear registers
// sit beside the FIFO.
//
// Register map (byte offset in s_addr):
//   0x00 CTRL     R/W  bit0 int_en
//   0x01 INT_CLR  W    any write clears interrupt, ovf and udf
//   0x02 STATUS   RO   bit0 empty, bit1 full, bit2 ovf, bit3 udf,
//                      bits[8+DEPTH_LOG2:8] count
//   0x03 THRESH   R/W  bits[DEPTH_LOG2:0], 0 disables the threshold event
//   0x04 DATA     W pushes, R pops
//   0x05 PEEK     RO   head word without popping, 0 when empty
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   s_sel      slave select from the bus address decoder
//   s_wr       1 = write, 0 = read (qualified by s_sel)
//   s_addr     register offset
//   s_din      write data
//   s_dout     read data, combinational; 0 unless a read is selected
//   interrupt  sticky interrupt request, registered
// -----------------------------------------------------------------------------
module bus_fifo_slave #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [7:0]  s_addr,
    input  logic [31:0] s_din,
    output logic [31:0] s_dout,
    output logic        interrupt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_INT_CLR = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_THRESH  = 8'h03;
    localparam logic [7:0] ADDR_DATA    = 8'h04;
    localparam logic [7:0] ADDR_PEEK    = 8'h05;

    // count == DEPTH is the MSB alone set
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [31:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic [DEPTH_LOG2:0]   thresh_q, thresh_d;
    logic                  int_en_q, int_en_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;
    logic                  irq_q,    irq_d;

    // Delayed copies used for rising-edge detection of the interrupt sources
    logic                  at_thr_q;
    logic                  at_thr_dly_q;
    logic                  ovf_dly_q;
    logic                  udf_dly_q;

    // ---------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------
    logic wr_access, rd_access;
    logic empty, full;
    logic push, pop, ovf_set, udf_set, int_clr;
    logic at_thr_now;
    logic thr_event, ovf_event, udf_event;

    assign wr_access = s_sel &  s_wr;
    assign rd_access = s_sel & ~s_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    assign push    = wr_access && (s_addr == ADDR_DATA) && !full;
    assign pop     = rd_access && (s_addr == ADDR_DATA) && !empty;
    assign ovf_set = wr_access && (s_addr == ADDR_DATA) &&  full;
    assign udf_set = rd_access && (s_addr == ADDR_DATA) &&  empty;
    assign int_clr = wr_access && (s_addr == ADDR_INT_CLR);

    assign at_thr_now = (thresh_q != '0) && (count_q >= thresh_q);

    // at_thr is registered first and its edge is then detected against a
    // second copy, so a threshold crossing raises interrupt two edges after
    // the push that caused it. ovf/udf edges are seen one edge after the flag.
    assign thr_event = at_thr_q & ~at_thr_dly_q;
    assign ovf_event = ovf_q    & ~ovf_dly_q;
    assign udf_event = udf_q    & ~udf_dly_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        thresh_d = thresh_q;
        int_en_d = int_en_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        irq_d    = irq_q;

        // push and pop are mutually exclusive: one bus access per cycle
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            count_d  = count_q + (DEPTH_LOG2 + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            count_d  = count_q - (DEPTH_LOG2 + 1)'(1);
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (udf_set) begin
            udf_d = 1'b1;
        end

        if (wr_access && (s_addr == ADDR_CTRL)) begin
            int_en_d = s_din[0];
        end
        if (wr_access && (s_addr == ADDR_THRESH)) begin
            thresh_d = s_din[DEPTH_LOG2:0];
        end

        // Events while int_en is low are dropped, not queued
        if (int_en_q && (thr_event || ovf_event || udf_event)) begin
            irq_d = 1'b1;
        end

        // Clear has priority over any coincident set
        if (int_clr) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            thresh_q     <= (DEPTH_LOG2 + 1)'(1);
            int_en_q     <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            irq_q        <= 1'b0;
            at_thr_q     <= 1'b0;
            at_thr_dly_q <= 1'b0;
            ovf_dly_q    <= 1'b0;
            udf_dly_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            thresh_q     <= thresh_d;
            int_en_q     <= int_en_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            irq_q        <= irq_d;
            at_thr_q     <= at_thr_now;
            at_thr_dly_q <= at_thr_q;
            ovf_dly_q    <= ovf_q;
            udf_dly_q    <= udf_q;
        end
    end

    // Storage is not reset; after a reset count is 0 so stale words are
    // never returned.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr_q] <= s_din;
        end
    end

    // ---------------------------------------------------------------------
    // Read mux (combinational, zero-latency reads)
    // ---------------------------------------------------------------------
    logic [31:0] status_w;

    always_comb begin
        status_w                   = '0;
        status_w[0]                = empty;
        status_w[1]                = full;
        status_w[2]                = ovf_q;
        status_w[3]                = udf_q;
        status_w[8 +: DEPTH_LOG2+1] = count_q;
    end

    always_comb begin
        s_dout = '0;
        if (rd_access) begin
            case (s_addr)
                ADDR_CTRL:   s_dout[0] = int_en_q;
                ADDR_STATUS: s_dout = status_w;
                ADDR_THRESH: s_dout[DEPTH_LOG2:0] = thresh_q;
                ADDR_DATA,
                ADDR_PEEK: begin
                    if (!empty) begin
                        s_dout = mem[rd_ptr_q];
                    end
                end
                default:     s_dout = '0;
            endcase
        end
    end

    assign interrupt = irq_q;

endmodule

// File: doc/bus_fifo_slave.md
# bus_fifo_slave

Memory-mapped FIFO responder for the system bus. The bus master (testbench or DMAC) writes 32-bit words into it, and a master or DMAC reads them back out in order. It holds status, threshold and interrupt registers. It sits on the slave side of the bus arbiter beside the RAMs and ALU, and is the receiving end of the writes the master issues.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 words (16 by default).
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s_sel  input  1  slave select from the bus address decoder.
- s_wr  input  1  1 = write, 0 = read; qualified by s_sel.
- s_addr  input  8  register offset within the slave.
- s_din  input  32  write data.
- s_dout  output  32  read data, combinational.
- interrupt  output  1  sticky interrupt request, registered.

## Operation
- Register map (offset: access):
  - 0x00 CTRL, R/W: bit0 int_en. Other bits read 0.
  - 0x01 INT_CLR, W: any write clears interrupt, ovf and udf. Reads 0.
  - 0x02 STATUS, RO: bit0 empty, bit1 full, bit2 ovf (sticky), bit3 udf (sticky), bits[8+DEPTH_LOG2:8] count.
  - 0x03 THRESH, R/W: bits[DEPTH_LOG2:0]. A value of 0 disables the threshold event.
  - 0x04 DATA: a write pushes, a read pops.
  - 0x05 PEEK, RO: head word without popping; 0 when empty.
  - Unmapped offsets read 0 and ignore writes.
- Storage: circular buffer indexed by wr_ptr and rd_ptr (DEPTH_LOG2 bits each).
  - Pointers wrap from DEPTH-1 to 0.
  - count is DEPTH_LOG2+1 bits, range 0..DEPTH.
  - empty = (count==0); full = (count==DEPTH).
- Push: happens when s_sel & s_wr & addr==0x04 & !full.
  - mem[wr_ptr] <= s_din, wr_ptr+1, count+1.
  - Write while full: data is dropped, pointers and count are unchanged, ovf <= 1.
- Pop: happens when s_sel & !s_wr & addr==0x04 & !empty.
  - s_dout = mem[rd_ptr] in the same cycle; rd_ptr+1 and count-1 at the edge.
  - Read while empty: s_dout = 0, udf <= 1, no state change.
- Only one bus access is possible per cycle, so a simultaneous push and pop cannot occur.
- Threshold event:
  - at_thr = (THRESH!=0) & (count>=THRESH), registered each cycle.
  - The event is the rising edge of at_thr.
  - Writing THRESH to a value already met by count produces an event on the next cycle.
- Interrupt set: interrupt <= 1 on a threshold event, or on an ovf/udf 0→1 transition, but only when int_en=1.
  - Events while int_en=0 are not remembered for later.
- Interrupt clear: an INT_CLR write clears interrupt, ovf and udf.
  - If a set event occurs in the same cycle, clear wins.
- s_dout = 0 whenever !(s_sel & !s_wr).

## Timing
- Reset values: interrupt=0, s_dout=0 (unselected), CTRL=0, THRESH=1, count=0, wr_ptr=0, rd_ptr=0, ovf=0, udf=0, at_thr=0.
- Memory contents are not reset.
- Reset dominates any bus access in the same cycle.
- Reset mid-operation empties the FIFO. Stale data is unreachable afterwards: a PEEK returns 0.
- Write latency: a word pushed at edge N is readable via DATA/PEEK in cycle N+1.
- Read latency: 0 cycles; s_dout is valid in the cycle s_addr/s_sel are presented.
- Register update latency: STATUS reflects a push/pop from the next cycle.
- Interrupt latency: interrupt rises 2 edges after the triggering push, i.e. at_thr registers first, then interrupt sets.
  - ovf/udf-triggered interrupt rises 1 edge after the flag sets.
- Back-to-back DATA accesses every cycle are supported with no wait states.

## Test plan
- Reset, then read STATUS → 0x0000_0001 (empty). Read THRESH → 1. interrupt=0. s_dout=0 when unselected.
- Push 0x10, 0x11, 0x12; PEEK → 0x10; pop three times → 0x10, 0x11, 0x12 in order; STATUS → empty with count 0. Then push and pop 20 words through a 16-deep FIFO and check order holds across pointer wrap.
- Push 17 words (0x100..0x110) → STATUS shows full, count 16, ovf=1. 0x110 is lost; pops return 0x100..0x10F. With int_en=1, interrupt is asserted.
- From empty, pop → s_dout=0, udf=1; write INT_CLR → ovf/udf/interrupt all 0.
- CTRL=1, THRESH=4, push 4 words → interrupt=1 exactly 2 edges after the 4th push and not earlier. INT_CLR → interrupt=0 and stays 0 while count remains 4. Pop 1 and push 1 → interrupt reasserts.
- Push 5 words, assert reset for 1 cycle mid-sequence → count=0, CTRL=0, THRESH=1, interrupt=0, PEEK=0. Next push/pop pair returns the new word.
